// File: rtl/alu_pkg.sv
// alu_pkg: shared collector states, opcode width/count and the ALU opcode set
package alu_pkg;

    localparam int OPW    = 3;
    localparam int OP_CNT = 6;

    typedef enum logic [1:0] {
        GET_OP = 2'd0,
        GET_A  = 2'd1,
        GET_B  = 2'd2,
        ISSUE  = 2'd3
    } state_e;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5
    } alu_op_e;

endpackage

// File: rtl/alu_frame_reg.sv
// alu_frame_reg: opcode / operand A / operand B capture registers with per-field load enables
module alu_frame_reg #(
    parameter int w   = 8,
    parameter int opw = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_ld_op,
    input  logic           i_ld_a,
    input  logic           i_ld_b,
    input  logic [w-1:0]   i_d,
    output logic [opw-1:0] o_op,
    output logic [w-1:0]   o_a,
    output logic [w-1:0]   o_b
);

    logic [opw-1:0] r_op;
    logic [w-1:0]   r_a;
    logic [w-1:0]   r_b;

    // each field loads only on its own enable, so fields hold between frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else begin
            if (i_ld_op) r_op <= i_d[opw-1:0];
            if (i_ld_a)  r_a  <= i_d;
            if (i_ld_b)  r_b  <= i_d;
        end
    end

    assign o_op = r_op;
    assign o_a  = r_a;
    assign o_b  = r_b;

endmodule

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: gathers opcode/A/B stream words into frames for the ALU.
// Optional opcode rejection (err pulse) is enabled by defining ALU_OPCODE_CHECK_EN.
module alu_operand_collector
    import alu_pkg::*;
#(
    parameter int w      = 8,
    parameter int opw    = OPW,
    parameter int op_cnt = OP_CNT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_in,
    input  logic [w-1:0]   in,
    output logic           ready_in,
    output logic           valid_out,
    input  logic           ready_out,
    output logic [opw-1:0] op,
    output logic [w-1:0]   a,
    output logic [w-1:0]   b,
    output logic [7:0]     frame_cnt,
    output logic           err
);

`ifdef ALU_OPCODE_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    localparam logic [opw:0] OP_LIM = op_cnt[opw:0];

    state_e     r_state;
    state_e     w_next;
    logic [7:0] r_frame_cnt;
    logic       r_err;
    logic       w_xfer_in;
    logic       w_xfer_out;
    logic       w_op_ok;
    logic       w_ld_op;
    logic       w_ld_a;
    logic       w_ld_b;

    assign ready_in   = (r_state != ISSUE);
    assign valid_out  = (r_state == ISSUE);
    assign w_xfer_in  = valid_in & ready_in;
    assign w_xfer_out = valid_out & ready_out;
    assign w_op_ok    = !CHECK || ({1'b0, in[opw-1:0]} < OP_LIM);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= GET_OP;
        else      r_state <= w_next;
    end

    // next state and field load enables; a rejected opcode is consumed without advancing
    always_comb begin
        w_next  = r_state;
        w_ld_op = 1'b0;
        w_ld_a  = 1'b0;
        w_ld_b  = 1'b0;
        case (r_state)
            GET_OP: if (w_xfer_in && w_op_ok) begin
                w_ld_op = 1'b1;
                w_next  = GET_A;
            end
            GET_A: if (w_xfer_in) begin
                w_ld_a = 1'b1;
                w_next = GET_B;
            end
            GET_B: if (w_xfer_in) begin
                w_ld_b = 1'b1;
                w_next = ISSUE;
            end
            ISSUE: if (w_xfer_out) w_next = GET_OP;
            default: w_next = GET_OP;
        endcase
    end

    // issued-frame counter, wraps naturally at 8 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            r_frame_cnt <= '0;
        else if (w_xfer_out) r_frame_cnt <= r_frame_cnt + 8'd1;
    end

    // one-cycle pulse after an opcode word is rejected; never set when checking is off
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err <= 1'b0;
        else      r_err <= w_xfer_in && (r_state == GET_OP) && !w_op_ok;
    end

    alu_frame_reg #(.w(w), .opw(opw)) u_frame (
        .clk    (clk),
        .rst    (rst),
        .i_ld_op(w_ld_op),
        .i_ld_a (w_ld_a),
        .i_ld_b (w_ld_b),
        .i_d    (in),
        .o_op   (op),
        .o_a    (a),
        .o_b    (b)
    );

    assign frame_cnt = r_frame_cnt;
    assign err       = r_err;

endmodule
